updown_mod_counter: RTL

Parametrised synchronous modulo counter that supersedes the fixed 4-bit toggle-enabled counter. It adds configurable width and modulus, up/down direction, parallel load, synchronous clear, a registered terminal-count pulse and a rollover event counter. It sits in the counters library as the general-purpose count/divide block for timers, clock-enable generation and event tallies.

---
 rtl/counter_pkg.sv | 18 +
 rtl/count_next.sv | 30 +++
 rtl/updown_mod_counter.sv | 69 ++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counters library.
package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_MODULO = 16;
  localparam int DEF_WRAP_W = 8;

  // Legal moduli are 2..2^width so that every count value fits in the width.
  function automatic bit modulo_ok(input int width, input int modulo);
    longint unsigned span;
    span = longint'(1) << width;
    return (modulo >= 2) && (longint'(modulo) <= span);
  endfunction

endpackage

// File: rtl/count_next.sv
// Combinational next-count step for updown_mod_counter.
// COUNTER_SAT_EN selects saturate-at-bound instead of wrap-at-bound.
module count_next
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] bound,
  output logic [WIDTH-1:0] q_next,
  output logic             at_bound
);

  always_comb begin
    at_bound = (up_dn == DIR_UP) ? (q == bound) : (q == '0);
    q_next   = q;
    if (at_bound) begin
`ifdef COUNTER_SAT_EN
      q_next = q;
`else
      q_next = (up_dn == DIR_UP) ? '0 : bound;
`endif
    end else begin
      // Off the bound the step cannot overflow WIDTH bits.
      q_next = (up_dn == DIR_UP) ? q + WIDTH'(1) : q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with load, clear, terminal-count pulse
// and saturating rollover tally. COUNTER_SAT_EN makes the count saturate.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int MODULO = DEF_MODULO,
  parameter int WRAP_W = DEF_WRAP_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              T,
  input  logic              up_dn,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              clear,
  output logic [WIDTH-1:0]  Q,
  output logic              tc,
  output logic [WRAP_W-1:0] wrap_cnt
);

  generate
    if (!modulo_ok(WIDTH, MODULO)) begin : g_bad_modulo
      $error("updown_mod_counter: MODULO must be in 2..2^WIDTH");
    end
  endgenerate

  // MODULO itself may equal 2^WIDTH, so compare in a WIDTH+1 bit domain.
  localparam logic [WIDTH:0] MOD_X   = (WIDTH + 1)'(MODULO);
  localparam logic [WIDTH:0] BOUND_X = MOD_X - 1'b1;
  localparam logic [WIDTH-1:0] BOUND = BOUND_X[WIDTH-1:0];

  logic [WIDTH-1:0] q_next;
  logic             at_bound;
  logic [WIDTH-1:0] load_clamped;

  assign load_clamped = ({1'b0, load_val} >= MOD_X) ? BOUND : load_val;

  count_next #(.WIDTH(WIDTH)) u_count_next (
    .q        (Q),
    .up_dn    (up_dn),
    .bound    (BOUND),
    .q_next   (q_next),
    .at_bound (at_bound)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Q        <= '0;
      tc       <= 1'b0;
      wrap_cnt <= '0;
    end else if (clear) begin
      Q  <= '0;
      tc <= 1'b0;
    end else if (load) begin
      Q  <= load_clamped;
      tc <= 1'b0;
    end else if (T) begin
      Q  <= q_next;
      tc <= at_bound;
      if (at_bound && (wrap_cnt != '1)) begin
        wrap_cnt <= wrap_cnt + 1'b1;
      end
    end else begin
      tc <= 1'b0;
    end
  end

endmodule
